// File: rtl/fused_pkg.sv
// Shared types for the fused-layer global fetch path: fetch FSM states, stream ids
// and default bus widths.
package fused_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_W1,
        FETCH_W2,
        FETCH_IFM,
        DONE
    } fetch_state_e;

    typedef enum logic [1:0] {
        W1,
        W2,
        IFM
    } stream_id_e;

    // First phase that still has words to move, in the fixed W1 -> W2 -> IFM order.
    // Empty phases fall straight through, so a run of zero-size regions costs no cycles.
    function automatic fetch_state_e first_live_phase(input logic has_w1,
                                                      input logic has_w2,
                                                      input logic has_ifm);
        fetch_state_e nxt;
        nxt = DONE;
        if (has_ifm) nxt = FETCH_IFM;
        if (has_w2)  nxt = FETCH_W2;
        if (has_w1)  nxt = FETCH_W1;
        return nxt;
    endfunction

endpackage

// File: rtl/region_counter.sv
// One BRAM region being streamed: latched base and size, plus the count of words
// already issued. Addresses wrap modulo 2^ADDR_W.
module region_counter
    import fused_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] size_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] size_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Region geometry is plain data; it is only consulted while a run is active.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            base_q <= base_i;
            size_q <= size_i;
        end
    end

    assign addr_o  = base_q + cnt_q;
    assign last_o  = (cnt_q + ADDR_W'(1)) == size_q;
    assign empty_o = cnt_q == size_q;

endmodule

// File: rtl/global_fetch_scheduler.sv
// Streams the layer-1 weight, layer-2 weight and IFM regions out of the global BRAM,
// in that order, to their on-chip buffers once the initial loader has released the BRAM.
module global_fetch_scheduler
    import fused_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_phase,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr_w1,
    input  logic [ADDR_W-1:0] size_w1,
    input  logic [ADDR_W-1:0] base_addr_w2,
    input  logic [ADDR_W-1:0] size_w2,
    input  logic [ADDR_W-1:0] base_addr_ifm,
    input  logic [ADDR_W-1:0] size_ifm,
    input  logic              w1_ready,
    input  logic              w2_ready,
    input  logic              ifm_ready,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              w1_valid,
    output logic              w2_valid,
    output logic              ifm_valid,
    output logic              busy,
    output logic              done,
    output logic              err_abort
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic              ret_vld_q;
    stream_id_e        ret_sid_q;

    logic              accept;
    logic              abort;
    logic              issue;
    stream_id_e        issue_sid;
    logic [ADDR_W-1:0] issue_addr;

    logic [ADDR_W-1:0] w1_addr;
    logic [ADDR_W-1:0] w2_addr;
    logic [ADDR_W-1:0] ifm_addr;
    logic              w1_last;
    logic              w2_last;
    logic              ifm_last;
    logic              w1_empty;
    logic              w2_empty;
    logic              ifm_empty;

    region_counter #(.ADDR_W(ADDR_W)) u_w1 (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (accept),
        .base_i  (base_addr_w1),
        .size_i  (size_w1),
        .inc_i   (issue && (issue_sid == W1)),
        .addr_o  (w1_addr),
        .last_o  (w1_last),
        .empty_o (w1_empty)
    );

    region_counter #(.ADDR_W(ADDR_W)) u_w2 (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (accept),
        .base_i  (base_addr_w2),
        .size_i  (size_w2),
        .inc_i   (issue && (issue_sid == W2)),
        .addr_o  (w2_addr),
        .last_o  (w2_last),
        .empty_o (w2_empty)
    );

    region_counter #(.ADDR_W(ADDR_W)) u_ifm (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (accept),
        .base_i  (base_addr_ifm),
        .size_i  (size_ifm),
        .inc_i   (issue && (issue_sid == IFM)),
        .addr_o  (ifm_addr),
        .last_o  (ifm_last),
        .empty_o (ifm_empty)
    );

    // Issue is combinational on ready so a phase boundary costs no bubble; the cycle of
    // a phase's last issue already selects the next live phase.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        abort      = 1'b0;
        issue      = 1'b0;
        issue_sid  = W1;
        issue_addr = '0;
        case (state_q)
            IDLE: begin
                if (start && !load_phase) begin
                    accept  = 1'b1;
                    state_d = first_live_phase(size_w1 != '0, size_w2 != '0, size_ifm != '0);
                end
            end
            FETCH_W1: begin
                if (load_phase) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (w1_ready && !w1_empty) begin
                    issue      = 1'b1;
                    issue_sid  = W1;
                    issue_addr = w1_addr;
                    if (w1_last) begin
                        state_d = first_live_phase(1'b0, !w2_empty, !ifm_empty);
                    end
                end
            end
            FETCH_W2: begin
                if (load_phase) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (w2_ready && !w2_empty) begin
                    issue      = 1'b1;
                    issue_sid  = W2;
                    issue_addr = w2_addr;
                    if (w2_last) begin
                        state_d = first_live_phase(1'b0, 1'b0, !ifm_empty);
                    end
                end
            end
            FETCH_IFM: begin
                if (load_phase) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (ifm_ready && !ifm_empty) begin
                    issue      = 1'b1;
                    issue_sid  = IFM;
                    issue_addr = ifm_addr;
                    if (ifm_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The return tag follows each read by exactly one cycle; reset drops any in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ret_vld_q <= 1'b0;
            ret_sid_q <= W1;
        end else begin
            state_q   <= state_d;
            ret_vld_q <= issue;
            ret_sid_q <= issue_sid;
        end
    end

    assign bram_rd_en   = issue;
    assign bram_rd_addr = issue_addr;
    assign rd_data      = bram_rd_data;
    assign w1_valid     = ret_vld_q && (ret_sid_q == W1);
    assign w2_valid     = ret_vld_q && (ret_sid_q == W2);
    assign ifm_valid    = ret_vld_q && (ret_sid_q == IFM);
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign err_abort    = abort;

endmodule

// File: tb/tb_global_fetch_scheduler.sv
// Directed bench for global_fetch_scheduler: cycle-by-cycle expected strobes,
// addresses, stream valids and returned data against hand-written vectors.
module tb_global_fetch_scheduler;

    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_phase;
    logic          start;
    logic [AW-1:0] base_addr_w1, size_w1, base_addr_w2, size_w2, base_addr_ifm, size_ifm;
    logic          w1_ready, w2_ready, ifm_ready;
    logic          bram_rd_en;
    logic [AW-1:0] bram_rd_addr;
    logic [DW-1:0] bram_rd_data;
    logic [DW-1:0] rd_data;
    logic          w1_valid, w2_valid, ifm_valid;
    logic          busy, done, err_abort;

    int            errors = 0;
    int            checks = 0;
    int            n_v1, n_v2, n_vi;
    logic [AW-1:0] last_iss_addr = '0;

    always #5 clk = ~clk;

    global_fetch_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_phase    (load_phase),
        .start         (start),
        .base_addr_w1  (base_addr_w1),
        .size_w1       (size_w1),
        .base_addr_w2  (base_addr_w2),
        .size_w2       (size_w2),
        .base_addr_ifm (base_addr_ifm),
        .size_ifm      (size_ifm),
        .w1_ready      (w1_ready),
        .w2_ready      (w2_ready),
        .ifm_ready     (ifm_ready),
        .bram_rd_en    (bram_rd_en),
        .bram_rd_addr  (bram_rd_addr),
        .bram_rd_data  (bram_rd_data),
        .rd_data       (rd_data),
        .w1_valid      (w1_valid),
        .w2_valid      (w2_valid),
        .ifm_valid     (ifm_valid),
        .busy          (busy),
        .done          (done),
        .err_abort     (err_abort)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a ^ 32'hC0DE0000, ~a, a, 32'h5A5A5A5A};
    endfunction

    // Single-port BRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (bram_rd_en) bram_rd_data <= pat(bram_rd_addr);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected control vector is {rd_en, w1_valid, w2_valid, ifm_valid, done, busy, err_abort}.
    task automatic expect_cyc(input string tag, input bit en, input logic [AW-1:0] addr,
                              input bit v1, input bit v2, input bit vi,
                              input bit dn, input bit bz, input bit er);
        #1;
        chk({tag, ".ctl"}, {bram_rd_en, w1_valid, w2_valid, ifm_valid, done, busy, err_abort},
            {en, v1, v2, vi, dn, bz, er});
        if (en) chk({tag, ".addr"}, bram_rd_addr, addr);
        if (v1 || v2 || vi) chk({tag, ".data"}, rd_data, pat(last_iss_addr));
        if (en) last_iss_addr = addr;
        n_v1 += int'(w1_valid);
        n_v2 += int'(w2_valid);
        n_vi += int'(ifm_valid);
    endtask

    task automatic cfg(input logic [AW-1:0] b1, input logic [AW-1:0] s1,
                       input logic [AW-1:0] b2, input logic [AW-1:0] s2,
                       input logic [AW-1:0] bi, input logic [AW-1:0] si);
        base_addr_w1  = b1;
        size_w1       = s1;
        base_addr_w2  = b2;
        size_w2       = s2;
        base_addr_ifm = bi;
        size_ifm      = si;
        n_v1 = 0;
        n_v2 = 0;
        n_vi = 0;
    endtask

    initial begin
        reset      = 1'b1;
        load_phase = 1'b0;
        start      = 1'b0;
        w1_ready   = 1'b1;
        w2_ready   = 1'b1;
        ifm_ready  = 1'b1;
        cfg(32'h100, 4, 32'h200, 2, 32'h0, 3);

        // Reset state
        tick();
        tick();
        expect_cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst.addr0", bram_rd_addr, 0);
        reset = 1'b0;
        tick();

        // Basic three-region run with every ready high
        start = 1'b1; expect_cyc("base.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("base.c1", 1, 32'h100, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("base.c2", 1, 32'h101, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("base.c3", 1, 32'h102, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("base.c4", 1, 32'h103, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("base.c5", 1, 32'h200, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("base.c6", 1, 32'h201, 0, 1, 0, 0, 1, 0); tick();
        expect_cyc("base.c7", 1, 32'h000, 0, 1, 0, 0, 1, 0); tick();
        expect_cyc("base.c8", 1, 32'h001, 0, 0, 1, 0, 1, 0); tick();
        expect_cyc("base.c9", 1, 32'h002, 0, 0, 1, 0, 1, 0); tick();
        expect_cyc("base.c10", 0, 0, 0, 0, 1, 1, 1, 0); tick();
        expect_cyc("base.c11", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // w2_ready low for three cycles of FETCH_W2, plus a start while busy
        cfg(32'h100, 4, 32'h200, 2, 32'h0, 3);
        start = 1'b1; expect_cyc("stall.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("stall.c1", 1, 32'h100, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("stall.c2", 1, 32'h101, 1, 0, 0, 0, 1, 0); tick();
        start = 1'b1;
        base_addr_w1 = 32'h900; base_addr_w2 = 32'hA00; base_addr_ifm = 32'hB00; size_w2 = 7;
        expect_cyc("stall.c3", 1, 32'h102, 1, 0, 0, 0, 1, 0); tick();
        start = 1'b0;
        expect_cyc("stall.c4", 1, 32'h103, 1, 0, 0, 0, 1, 0); tick();
        w2_ready = 1'b0;
        expect_cyc("stall.c5", 0, 0, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("stall.c6", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("stall.c7", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        w2_ready = 1'b1;
        expect_cyc("stall.c8", 1, 32'h200, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("stall.c9", 1, 32'h201, 0, 1, 0, 0, 1, 0); tick();
        expect_cyc("stall.c10", 1, 32'h000, 0, 1, 0, 0, 1, 0); tick();
        expect_cyc("stall.c11", 1, 32'h001, 0, 0, 1, 0, 1, 0); tick();
        expect_cyc("stall.c12", 1, 32'h002, 0, 0, 1, 0, 1, 0); tick();
        expect_cyc("stall.c13", 0, 0, 0, 0, 1, 1, 1, 0); tick();
        expect_cyc("stall.c14", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall.n_w1", n_v1, 4);
        chk("stall.n_w2", n_v2, 2);
        chk("stall.n_ifm", n_vi, 3);
        tick();

        // Two skipped zero-size phases, single IFM word at the top of the address space
        cfg(32'h100, 0, 32'h200, 0, 32'hFFFF_FFFF, 1);
        start = 1'b1; expect_cyc("one.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("one.c1", 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("one.c2", 0, 0, 0, 0, 1, 1, 1, 0); tick();
        expect_cyc("one.c3", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Address wrap
        cfg(32'h100, 0, 32'h200, 0, 32'hFFFF_FFFF, 2);
        start = 1'b1; expect_cyc("wrap.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("wrap.c1", 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("wrap.c2", 1, 32'h0000_0000, 0, 0, 1, 0, 1, 0); tick();
        expect_cyc("wrap.c3", 0, 0, 0, 0, 1, 1, 1, 0); tick();
        expect_cyc("wrap.c4", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // All sizes zero
        cfg(32'h100, 0, 32'h200, 0, 32'h300, 0);
        start = 1'b1; expect_cyc("zero.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("zero.c1", 0, 0, 0, 0, 0, 1, 1, 0); tick();
        expect_cyc("zero.c2", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // load_phase raised at cycle 3 of an 8-word W1 fetch
        cfg(32'h40, 8, 32'h80, 2, 32'hC0, 2);
        start = 1'b1; expect_cyc("abort.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("abort.c1", 1, 32'h40, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("abort.c2", 1, 32'h41, 1, 0, 0, 0, 1, 0); tick();
        load_phase = 1'b1;
        expect_cyc("abort.c3", 0, 0, 1, 0, 0, 0, 1, 1); tick();
        load_phase = 1'b0;
        expect_cyc("abort.c4", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        expect_cyc("abort.c5", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        expect_cyc("abort.c6", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // start held while the loader owns the BRAM
        cfg(32'h100, 4, 32'h200, 2, 32'h0, 3);
        start = 1'b1; load_phase = 1'b1;
        expect_cyc("ldst.c0", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        expect_cyc("ldst.c1", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        expect_cyc("ldst.c2", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        start = 1'b0; load_phase = 1'b0;
        expect_cyc("ldst.c3", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // One-cycle reset in the middle of FETCH_W2
        cfg(32'h100, 4, 32'h200, 2, 32'h0, 3);
        start = 1'b1; expect_cyc("mrst.c0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); start = 1'b0;
        expect_cyc("mrst.c1", 1, 32'h100, 0, 0, 0, 0, 1, 0); tick();
        expect_cyc("mrst.c2", 1, 32'h101, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("mrst.c3", 1, 32'h102, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("mrst.c4", 1, 32'h103, 1, 0, 0, 0, 1, 0); tick();
        expect_cyc("mrst.c5", 1, 32'h200, 1, 0, 0, 0, 1, 0); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        expect_cyc("mrst.c7", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mrst.addr0", bram_rd_addr, 0);
        tick();
        expect_cyc("mrst.c8", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
